// File: rtl/ucsbece154_dmem_pkg.sv
// Shared constants and address-window checks for the multi-port data memory.
// A legal access is word-aligned and lies inside the memory window.
package ucsbece154_dmem_pkg;

    localparam logic [31:0] DATA_START_DEFAULT = 32'h1000_0000;
    localparam int          WORD_W             = 32;
    localparam int          BYTE_W             = 8;
    localparam int          BYTES_PER_WORD     = WORD_W / BYTE_W;

    // The upper limit is computed in 33 bits so a window ending at 2^32 cannot wrap.
    function automatic logic addr_ok(
        input logic [31:0] a,
        input logic [31:0] base,
        input int          words
    );
        logic [32:0] lim;
        logic        in_range;
        logic        aligned;
        lim      = {1'b0, base} + ({1'b0, 32'(words)} << 2);
        in_range = (a >= base) && ({1'b0, a} < lim);
        aligned  = (a[1:0] == 2'b00);
        return in_range && aligned;
    endfunction

endpackage

// File: rtl/ucsbece154_dmem_fwd_merge.sv
// Store-to-load forwarding for one load lane: overlays the bytes of every legal
// same-cycle store from an older (lower-index) lane that targets the same word.
module ucsbece154_dmem_fwd_merge
    import ucsbece154_dmem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 6,
    parameter int LANE      = 0
) (
    input  logic [WORD_W-1:0]             arr_word_i,
    input  logic [AW-1:0]                 idx_i,
    input  logic [NUM_PORTS-1:0]          st_legal_i,
    input  logic [NUM_PORTS*AW-1:0]       st_idx_i,
    input  logic [BYTES_PER_WORD*NUM_PORTS-1:0] be_i,
    input  logic [WORD_W*NUM_PORTS-1:0]   wd_i,
    output logic [WORD_W-1:0]             fwd_o
);

    // Ascending lane order makes the youngest older store win on each byte.
    always_comb begin
        fwd_o = arr_word_i;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (i < LANE && st_legal_i[i] && (st_idx_i[AW*i +: AW] == idx_i)) begin
                for (int b = 0; b < BYTES_PER_WORD; b++) begin
                    if (be_i[BYTES_PER_WORD*i + b]) begin
                        fwd_o[BYTE_W*b +: BYTE_W] = wd_i[WORD_W*i + BYTE_W*b +: BYTE_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ucsbece154_dmem_mp.sv
// Multi-port MEM-stage data memory: byte-enable stores, registered loads, in-bundle
// forwarding from older lanes, youngest-lane-wins writes and per-access error reporting.
module ucsbece154_dmem_mp
    import ucsbece154_dmem_pkg::*;
#(
    parameter int          NUM_PORTS  = 2,
    parameter int          DATA_SIZE  = 64,
    parameter logic [31:0] DATA_START = DATA_START_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rstn_i,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS-1:0]          we_i,
    input  logic [4*NUM_PORTS-1:0]        be_i,
    input  logic [32*NUM_PORTS-1:0]       a_i,
    input  logic [32*NUM_PORTS-1:0]       wd_i,
    output logic [32*NUM_PORTS-1:0]       rd_o,
    output logic [NUM_PORTS-1:0]          rvalid_o,
    output logic [NUM_PORTS-1:0]          err_o,
    output logic                          err_sticky_o,
    input  logic                          err_clr_i
);

    localparam int AW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    logic [WORD_W-1:0] mem_q [DATA_SIZE];

    logic [NUM_PORTS-1:0]        ok_w;
    logic [NUM_PORTS-1:0]        st_legal_w;
    logic [NUM_PORTS-1:0]        ld_req_w;
    logic [NUM_PORTS*AW-1:0]     idx_w;
    logic [32*NUM_PORTS-1:0]     arr_word_w;
    logic [32*NUM_PORTS-1:0]     fwd_w;

    logic [32*NUM_PORTS-1:0]     rd_q,     rd_d;
    logic [NUM_PORTS-1:0]        rvalid_q, rvalid_d;
    logic [NUM_PORTS-1:0]        err_q,    err_d;
    logic                        sticky_q, sticky_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_lane
            assign ok_w[gi]       = addr_ok(a_i[32*gi +: 32], DATA_START, DATA_SIZE);
            // Out-of-window addresses also get an index here, but ok_w masks every use.
            assign idx_w[AW*gi +: AW] = AW'((a_i[32*gi +: 32] - DATA_START) >> 2);
            assign st_legal_w[gi] = req_i[gi] & we_i[gi] & ok_w[gi];
            assign ld_req_w[gi]   = req_i[gi] & ~we_i[gi];
            assign err_d[gi]      = req_i[gi] & ~ok_w[gi];
            assign arr_word_w[32*gi +: 32] = mem_q[idx_w[AW*gi +: AW]];

            ucsbece154_dmem_fwd_merge #(
                .NUM_PORTS (NUM_PORTS),
                .AW        (AW),
                .LANE      (gi)
            ) u_fwd (
                .arr_word_i (arr_word_w[32*gi +: 32]),
                .idx_i      (idx_w[AW*gi +: AW]),
                .st_legal_i (st_legal_w),
                .st_idx_i   (idx_w),
                .be_i       (be_i),
                .wd_i       (wd_i),
                .fwd_o      (fwd_w[32*gi +: 32])
            );
        end
    endgenerate

    // Later non-blocking writes override earlier ones, so the highest lane wins per byte.
    // Stores seen while reset is held are discarded.
    always_ff @(posedge clk) begin
        if (rstn_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int b = 0; b < BYTES_PER_WORD; b++) begin
                    if (st_legal_w[p] && be_i[BYTES_PER_WORD*p + b]) begin
                        mem_q[idx_w[AW*p +: AW]][BYTE_W*b +: BYTE_W] <= wd_i[32*p + BYTE_W*b +: BYTE_W];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_d     = rd_q;
        rvalid_d = ld_req_w;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ld_req_w[p]) begin
                rd_d[32*p +: 32] = ok_w[p] ? fwd_w[32*p +: 32] : 32'h0;
            end
        end
        // A fresh error outranks a clear arriving in the same cycle.
        sticky_d = (sticky_q & ~err_clr_i) | (|err_d);
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_q     <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign rd_o         = rd_q;
    assign rvalid_o     = rvalid_q;
    assign err_o        = err_q;
    assign err_sticky_o = sticky_q;

endmodule
